// File: rtl/trunc_pkg.sv
// trunc_pkg: shared state encoding and truncation helper
// for the round-robin truncation scheduler.
package trunc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int TRUNC_MODE_BIT = 31;
  localparam int TRUNC_N_LSB    = 0;
  localparam int TRUNC_N_MSB    = 4;

  // mode=1 keeps the low n bits, mode=0 keeps the high n bits
  // shifted down; n=0 yields zero in both modes.
  function automatic logic [31:0] trunc32(
    input logic [31:0] a,
    input logic [31:0] b
  );
    logic [4:0] n;
    logic [5:0] s;
    n = b[TRUNC_N_MSB:TRUNC_N_LSB];
    s = 6'd32 - {1'b0, n};
    if (n == 5'd0)
      trunc32 = '0;
    else if (b[TRUNC_MODE_BIT])
      trunc32 = (a << s) >> s;
    else
      trunc32 = a >> s;
  endfunction

endpackage

// File: rtl/trunc_rr_pick.sv
// trunc_rr_pick: first valid requester at or after ptr,
// wrapping mod NREQ; one-hot grant plus its index.
module trunc_rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] i_valid,
  input  logic [IDW-1:0]  i_ptr,
  output logic [NREQ-1:0] o_grant,
  output logic [IDW-1:0]  o_idx,
  output logic            o_any
);

  // scan from the farthest slot back so the nearest one wins
  always_comb begin : pick
    int j;
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    j       = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = (int'(i_ptr) + k) % NREQ;
      if (i_valid[j]) begin
        o_grant    = '0;
        o_grant[j] = 1'b1;
        o_idx      = IDW'(j);
        o_any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/trunc_share_sched.sv
// trunc_share_sched: shares one truncation unit between
// NREQ requesters with round-robin grant and id return.
module trunc_share_sched
  import trunc_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2,
  parameter int CNTW = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [32*NREQ-1:0] req_a,
  input  logic [32*NREQ-1:0] req_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_data,
  output logic [IDW-1:0]    rsp_id,
  output logic              busy,
  output logic [CNTW-1:0]   done_cnt
);

  state_t            r_state;
  state_t            w_next;
  logic [IDW-1:0]    r_ptr;
  logic [IDW-1:0]    r_id;
  logic [31:0]       r_a;
  logic [31:0]       r_b;
  logic              r_rsp_valid;
  logic [31:0]       r_rsp_data;
  logic [IDW-1:0]    r_rsp_id;
  logic [CNTW-1:0]   r_done;
  logic [NREQ-1:0]   w_grant;
  logic [IDW-1:0]    w_idx;
  logic              w_any;
  logic              w_hs;
  logic              w_rsp_hs;

  trunc_rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .i_valid (req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  // next state and accept strobes; only IDLE ever accepts
  always_comb begin
    w_next    = r_state;
    req_ready = '0;
    w_hs      = 1'b0;
    w_rsp_hs  = r_rsp_valid && rsp_ready && (r_state == RESP);
    unique case (r_state)
      IDLE: begin
        if (!rst && w_any) begin
          req_ready = w_grant;
          w_hs      = 1'b1;
          w_next    = EXEC;
        end
      end
      EXEC: w_next = RESP;
      RESP: if (w_rsp_hs) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // operand capture, rotation pointer, result and counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr       <= '0;
      r_id        <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_id    <= '0;
      r_done      <= '0;
    end else begin
      if (w_hs) begin
        r_a   <= req_a[32*w_idx +: 32];
        r_b   <= req_b[32*w_idx +: 32];
        r_id  <= w_idx;
        r_ptr <= (w_idx == IDW'(NREQ - 1)) ? '0 : w_idx + 1'b1;
      end
      if (r_state == EXEC) begin
        r_rsp_data  <= trunc32(r_a, r_b);
        r_rsp_id    <= r_id;
        r_rsp_valid <= 1'b1;
      end
      if (w_rsp_hs) begin
        r_rsp_valid <= 1'b0;
        r_done      <= r_done + 1'b1;
      end
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_id    = r_rsp_id;
  assign busy      = (r_state != IDLE);
  assign done_cnt  = r_done;

endmodule

// File: tb/tb_trunc_share_sched.sv
// tb_trunc_share_sched: scoreboard bench with directed and
// random traffic against a behavioural truncation model.
module tb_trunc_share_sched;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [127:0] req_a;
  logic [127:0] req_b;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [31:0]  rsp_data;
  logic [1:0]   rsp_id;
  logic         busy;
  logic [15:0]  done_cnt;

  logic [31:0]  aa [4];
  logic [31:0]  bb [4];

  always #5 clk = ~clk;

  always_comb begin
    req_a = '0;
    req_b = '0;
    for (int i = 0; i < 4; i++) begin
      req_a[32*i +: 32] = aa[i];
      req_b[32*i +: 32] = bb[i];
    end
  end

  trunc_share_sched #(
    .NREQ (4),
    .IDW  (2),
    .CNTW (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .busy      (busy),
    .done_cnt  (done_cnt)
  );

  typedef struct {
    logic [31:0] d;
    logic [1:0]  id;
    int          cyc;
  } exp_t;

  exp_t        q [$];
  int          cyc = 0;
  int          ncmp = 0;
  int          nerr = 0;
  int          hs_cnt [4] = '{0, 0, 0, 0};
  int          mptr = 0;
  int          mdone = 0;
  int          chk_seq = 0;
  int          chk_kind = 0;
  logic [15:0] chk_done = '0;
  int          last_seq = 0;
  logic        pv = 1'b0;
  logic [31:0] pd = '0;
  logic [1:0]  pid = '0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] ref_trunc(
    input logic [31:0] a,
    input logic [31:0] b
  );
    int          n;
    logic [63:0] x;
    n = int'(b[4:0]);
    if (b[31]) x = {32'd0, a} & ((64'd1 << n) - 64'd1);
    else       x = {32'd0, a} >> (32 - n);
    return x[31:0];
  endfunction

  function automatic int ref_pick(input logic [3:0] v, input int p);
    for (int k = 0; k < 4; k++)
      if (v[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  task automatic check(
    input bit          ok,
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    ncmp++;
    if (!ok) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d",
               nm, act, exp, cyc);
    end
  endtask

  // observer + monitor: grant check, scoreboard push and pop
  always @(negedge clk) begin : mon
    int          g;
    logic [3:0]  er;
    exp_t        e;
    if (rst) begin
      check(req_ready == 4'b0, "rdy_in_rst", 32'(req_ready), 32'd0);
      q.delete();
      mptr  = 0;
      mdone = 0;
      pv    = 1'b0;
    end else begin
      g  = ref_pick(req_valid, mptr);
      er = 4'b0;
      if (q.size() == 0 && g >= 0) er[g] = 1'b1;
      check(req_ready == er, "grant", 32'(req_ready), 32'(er));
      check(busy == (q.size() != 0), "busy",
            32'(busy), 32'(q.size() != 0));
      if (q.size() == 0 && g >= 0) begin
        e.d   = ref_trunc(aa[g], bb[g]);
        e.id  = 2'(g);
        e.cyc = cyc;
        q.push_back(e);
        hs_cnt[g]++;
        mptr = (g + 1) % 4;
      end else if (rsp_valid) begin
        if (q.size() == 0) begin
          check(1'b0, "unexpected_rsp", 32'(rsp_id), 32'd0);
        end else begin
          if (!pv)
            check(cyc == q[0].cyc + 2, "latency",
                  32'(cyc - q[0].cyc), 32'd2);
          else
            check(rsp_data == pd && rsp_id == pid, "hold",
                  rsp_data, pd);
          if (rsp_ready) begin
            check(rsp_data == q[0].d, "rsp_data", rsp_data, q[0].d);
            check(rsp_id == q[0].id, "rsp_id",
                  32'(rsp_id), 32'(q[0].id));
            check(done_cnt == 16'(mdone), "done_cnt",
                  32'(done_cnt), 32'(16'(mdone)));
            mdone++;
            void'(q.pop_front());
            pv = 1'b0;
          end else begin
            pv = 1'b1;
          end
          pd  = rsp_data;
          pid = rsp_id;
        end
      end else begin
        pv = 1'b0;
      end
    end
    if (chk_seq != last_seq) begin
      last_seq = chk_seq;
      case (chk_kind)
        1: begin
          check(!rsp_valid, "rst_rsp_valid", 32'(rsp_valid), 32'd0);
          check(rsp_data == 32'd0, "rst_rsp_data", rsp_data, 32'd0);
          check(rsp_id == 2'd0, "rst_rsp_id", 32'(rsp_id), 32'd0);
          check(done_cnt == 16'd0, "rst_done", 32'(done_cnt), 32'd0);
          check(!busy, "rst_busy", 32'(busy), 32'd0);
        end
        2: check(done_cnt == chk_done, "done_total",
                 32'(done_cnt), 32'(chk_done));
        3: check(1'b0, "timeout", 32'd0, 32'd1);
        4: check(q.size() == 0, "drain", 32'(q.size()), 32'd0);
        default: ;
      endcase
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req_chk(input int k, input logic [15:0] d);
    chk_kind = k;
    chk_done = d;
    chk_seq++;
    step();
  endtask

  task automatic wait_hs(input int i);
    int c0;
    c0 = hs_cnt[i];
    for (int t = 0; t < 40; t++) begin
      step();
      if (hs_cnt[i] != c0) return;
    end
    req_chk(3, 16'd0);
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic one_op(input int i, input logic [31:0] a,
                        input logic [31:0] b);
    aa[i]        = a;
    bb[i]        = b;
    req_valid    = 4'b0;
    req_valid[i] = 1'b1;
    wait_hs(i);
    req_valid = 4'b0;
    repeat (3) step();
  endtask

  logic [31:0] bv [3] = '{32'h0000_0008, 32'h8000_0000, 32'h0};
  int          seen [4];

  initial begin
    rst       = 1'b1;
    req_valid = 4'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      aa[i] = '0;
      bb[i] = '0;
    end
    repeat (3) step();
    rst = 1'b0;
    req_chk(1, 16'd0);

    one_op(0, 32'hDEAD_BEEF, 32'h8000_0008);
    for (int k = 0; k < 3; k++)
      one_op(2, 32'hDEAD_BEEF, bv[k]);

    aa[3] = 32'h1234_5678;
    bb[3] = 32'h8000_0010;
    aa[1] = 32'hCAFE_F00D;
    bb[1] = 32'h0000_000C;
    req_valid = 4'b1000;
    wait_hs(3);
    req_valid = 4'b0010;
    rsp_ready = 1'b0;
    repeat (6) step();
    rsp_ready = 1'b1;
    wait_hs(1);
    req_valid = 4'b0;
    repeat (3) step();

    pulse_rst();
    for (int i = 0; i < 4; i++) begin
      aa[i] = $urandom;
      bb[i] = $urandom;
    end
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) wait_hs(k % 4);
    req_valid = 4'b0;
    repeat (3) step();
    req_chk(2, 16'd5);

    aa[0] = 32'hFFFF_FFFF;
    bb[0] = 32'h8000_0004;
    req_valid = 4'b0001;
    wait_hs(0);
    req_valid = 4'b0;
    pulse_rst();
    req_chk(1, 16'd0);
    req_valid = 4'b1111;
    wait_hs(0);
    req_valid = 4'b0;
    repeat (3) step();

    one_op(2, 32'h0F0F_0F0F, 32'h0000_0010);
    one_op(1, 32'hA5A5_5A5A, 32'h8000_001F);
    req_valid = 4'b1111;
    wait_hs(2);
    req_valid = 4'b0;
    repeat (3) step();

    for (int i = 0; i < 4; i++) seen[i] = hs_cnt[i];
    for (int t = 0; t < 1500; t++) begin
      for (int i = 0; i < 4; i++) begin
        if (hs_cnt[i] != seen[i]) begin
          seen[i]      = hs_cnt[i];
          req_valid[i] = ($urandom_range(0, 1) == 1);
          aa[i]        = $urandom;
          bb[i]        = $urandom;
        end else if (!req_valid[i]) begin
          if ($urandom_range(0, 2) == 0) begin
            req_valid[i] = 1'b1;
            aa[i]        = $urandom;
            bb[i]        = $urandom;
          end
        end else if ($urandom_range(0, 9) == 0) begin
          req_valid[i] = 1'b0;
        end else if ($urandom_range(0, 5) == 0) begin
          aa[i] = $urandom;
        end
        if ($urandom_range(0, 4) == 0)
          bb[i][4:0] = $urandom_range(0, 1) ? 5'd0 : 5'd31;
      end
      rsp_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 199) == 0) rst = 1'b1;
      step();
      rst = 1'b0;
    end

    req_valid = 4'b0;
    rsp_ready = 1'b1;
    repeat (10) step();
    req_chk(4, 16'd0);
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nerr);
    $finish;
  end

endmodule
